// File: rtl/sgtl_i2s_stream_tx_pkg.sv
// Shared types, default parameters and elaboration helpers for the SGTL5000 I2S transmit path.
package sgtl_audio_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_state_e;

    localparam int DEF_SAMPLE_W   = 24;
    localparam int DEF_SLOT_W     = 32;
    localparam int DEF_SCLK_DIV   = 4;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_MODE_I2S   = 1;

    // Level must represent 0..depth inclusive, hence one bit more than the pointer.
    function automatic int clog2_level(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit cfg_ok(input int sample_w, input int slot_w, input int sclk_div,
                                  input int fifo_depth, input int mode_i2s);
        return (sample_w >= 8) && (sample_w <= slot_w - mode_i2s)
            && (slot_w >= 16) && (slot_w <= 32)
            && (sclk_div >= 2) && ((sclk_div % 2) == 0)
            && (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0)
            && ((mode_i2s == 0) || (mode_i2s == 1));
    endfunction

endpackage

// File: rtl/sgtl_i2s_stream_tx_if.sv
// Stereo sample stream (valid/ready) feeding the I2S transmitter.
interface sgtl_i2s_stream_tx_if
    import sgtl_audio_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W
);
    logic                s_valid;
    logic                s_ready;
    logic [SAMPLE_W-1:0] s_left;
    logic [SAMPLE_W-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input  s_ready);
    modport slave  (input  s_valid, input  s_left, input  s_right, output s_ready);
endinterface

// File: rtl/sgtl_i2s_stream_tx_fifo.sv
// Synchronous frame FIFO with occupancy output; pop on empty and push on full are ignored.
module sgtl_sample_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             push_ok, pop_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_FULL);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/sgtl_i2s_stream_tx.sv
// I2S / left-justified master transmitter: MCLK-derived SCLK/LRCLK, frame FIFO, sticky underrun.
// state | meaning:  IDLE | clocks parked low, waiting for enable;  RUN | streaming frames back to back
module sgtl_i2s_stream_tx
    import sgtl_audio_pkg::*;
#(
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int SLOT_W     = DEF_SLOT_W,
    parameter int SCLK_DIV   = DEF_SCLK_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int MODE_I2S   = DEF_MODE_I2S
) (
    input  logic                                 MCLK,
    input  logic                                 reset,
    input  logic                                 enable,
    sgtl_i2s_stream_tx_if.slave                  s_if,
    output logic                                 SCLK,
    output logic                                 LRCLK,
    output logic                                 DOUT,
    output logic                                 frame_strobe,
    output logic [clog2_level(FIFO_DEPTH)-1:0]   fifo_level,
    output logic                                 underrun,
    input  logic                                 underrun_clr
);
    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_W);
    localparam int IDX_W = $clog2(SAMPLE_W);
    localparam int LVL_W = clog2_level(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] SLOT_CMP = BIT_W'(SLOT_W);

    if (!cfg_ok(SAMPLE_W, SLOT_W, SCLK_DIV, FIFO_DEPTH, MODE_I2S)) begin : g_cfg_err
        $error("sgtl_i2s_stream_tx: illegal parameter combination");
    end

    tx_state_e             state_q, state_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0]   left_q, left_d;
    logic [SAMPLE_W-1:0]   right_q, right_d;
    logic                  sclk_q, sclk_d;
    logic                  lrclk_q, lrclk_d;
    logic                  dout_q, dout_d;
    logic                  frame_strobe_q, frame_strobe_d;
    logic                  underrun_q, underrun_d;
    logic                  load;
    logic                  run_d;
    logic [BIT_W-1:0]      slot_pos;
    int                    slot_pos_i;
    logic [SAMPLE_W-1:0]   sample_sel;
    logic                  fifo_pop, fifo_empty, fifo_full;
    logic [2*SAMPLE_W-1:0] fifo_head;
    logic [LVL_W-1:0]      fifo_level_w;

    sgtl_sample_fifo #(
        .WIDTH (2 * SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (MCLK),
        .reset     (reset),
        .push      (s_if.s_valid),
        .push_data ({s_if.s_left, s_if.s_right}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level_w)
    );

    assign s_if.s_ready = !fifo_full;

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        left_d     = left_q;
        right_d    = right_q;
        underrun_d = underrun_q;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                if (enable) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (enable) load = 1'b1;
                        else        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear is applied first so a same-cycle underrun keeps the flag set.
        if (underrun_clr) underrun_d = 1'b0;
        if (load) begin
            if (fifo_empty) begin
                left_d     = '0;
                right_d    = '0;
                underrun_d = 1'b1;
            end else begin
                {left_d, right_d} = fifo_head;
            end
        end
        fifo_pop       = load && !fifo_empty;
        frame_strobe_d = load;

        // Pin values are derived from next-state counters so the registered pins line up with them.
        run_d      = (state_d == RUN);
        sclk_d     = run_d && (div_cnt_d >= DIV_HALF);
        lrclk_d    = run_d && (bit_cnt_d >= SLOT_CMP);
        slot_pos   = lrclk_d ? (bit_cnt_d - SLOT_CMP) : bit_cnt_d;
        slot_pos_i = int'(slot_pos);
        sample_sel = lrclk_d ? right_d : left_d;
        dout_d     = 1'b0;
        if (run_d && (slot_pos_i >= MODE_I2S) && (slot_pos_i < SAMPLE_W + MODE_I2S))
            dout_d = sample_sel[IDX_W'(SAMPLE_W - 1 + MODE_I2S - slot_pos_i)];
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            state_q        <= IDLE;
            div_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            left_q         <= '0;
            right_q        <= '0;
            sclk_q         <= 1'b0;
            lrclk_q        <= 1'b0;
            dout_q         <= 1'b0;
            frame_strobe_q <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            div_cnt_q      <= div_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            left_q         <= left_d;
            right_q        <= right_d;
            sclk_q         <= sclk_d;
            lrclk_q        <= lrclk_d;
            dout_q         <= dout_d;
            frame_strobe_q <= frame_strobe_d;
            underrun_q     <= underrun_d;
        end
    end

    assign SCLK         = sclk_q;
    assign LRCLK        = lrclk_q;
    assign DOUT         = dout_q;
    assign frame_strobe = frame_strobe_q;
    assign underrun     = underrun_q;
    assign fifo_level   = fifo_level_w;

endmodule

// File: tb/tb_sgtl_i2s_stream_tx.sv
// Bench for sgtl_i2s_stream_tx: I2S and left-justified instances driven identically, checked per MCLK cycle.
module tb_sgtl_i2s_stream_tx;
    localparam int SW    = 24;
    localparam int SL    = 32;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 2 * SL * DIV;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic MCLK = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic underrun_clr = 1'b0;

    always #5 MCLK = ~MCLK;

    sgtl_i2s_stream_tx_if #(.SAMPLE_W(SW)) if_a ();
    sgtl_i2s_stream_tx_if #(.SAMPLE_W(SW)) if_b ();

    logic             sclk_a, lrclk_a, dout_a, strobe_a, ur_a;
    logic             sclk_b, lrclk_b, dout_b, strobe_b, ur_b;
    logic [LVL_W-1:0] lvl_a, lvl_b;

    sgtl_i2s_stream_tx #(.SAMPLE_W(SW), .SLOT_W(SL), .SCLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .MODE_I2S(1)) dut_i2s (
        .MCLK(MCLK), .reset(reset), .enable(enable), .s_if(if_a),
        .SCLK(sclk_a), .LRCLK(lrclk_a), .DOUT(dout_a), .frame_strobe(strobe_a),
        .fifo_level(lvl_a), .underrun(ur_a), .underrun_clr(underrun_clr)
    );

    sgtl_i2s_stream_tx #(.SAMPLE_W(SW), .SLOT_W(SL), .SCLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .MODE_I2S(0)) dut_lj (
        .MCLK(MCLK), .reset(reset), .enable(enable), .s_if(if_b),
        .SCLK(sclk_b), .LRCLK(lrclk_b), .DOUT(dout_b), .frame_strobe(strobe_b),
        .fifo_level(lvl_b), .underrun(ur_b), .underrun_clr(underrun_clr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame queue, current frame, position within frame, sticky flag.
    logic [2*SW-1:0] model_q[$];
    logic [SW-1:0]   cur_l = '0;
    logic [SW-1:0]   cur_r = '0;
    int              c = 0;
    bit              running = 1'b0;
    bit              exp_ur = 1'b0;
    bit              last_fire = 1'b0;
    bit              last_strobe = 1'b0;

    // A slot is the sample MSB-first, padded with zeros, delayed by d bit periods.
    function automatic bit slot_bit(input logic [SW-1:0] smp, input int p, input int d);
        logic [SL-1:0] v;
        v = {smp, {(SL - SW){1'b0}}} >> d;
        return v[SL-1-p];
    endfunction

    task automatic drive(input bit v, input logic [SW-1:0] l, input logic [SW-1:0] r);
        if_a.s_valid = v; if_a.s_left = l; if_a.s_right = r;
        if_b.s_valid = v; if_b.s_left = l; if_b.s_right = r;
    endtask

    task automatic tick();
        bit              rst_e, en_e, clr_e, fire, strobe_e;
        bit              e_sclk, e_lr, e_da, e_db;
        logic [2*SW-1:0] pd, fr;
        logic [SW-1:0]   smp;
        int              b;
        rst_e = reset;
        en_e  = enable;
        clr_e = underrun_clr;
        fire  = if_a.s_valid && (model_q.size() != DEPTH);
        pd    = {if_a.s_left, if_a.s_right};
        @(posedge MCLK);
        #1;
        strobe_e = 1'b0;
        if (rst_e) begin
            model_q.delete();
            exp_ur  = 1'b0;
            running = 1'b0;
            c       = 0;
            fire    = 1'b0;
        end else begin
            strobe_e = running ? ((c == FRAME - 1) && en_e) : en_e;
            if (clr_e) exp_ur = 1'b0;
            if (strobe_e) begin
                if (model_q.size() == 0) begin
                    fr     = '0;
                    exp_ur = 1'b1;
                end else begin
                    fr = model_q.pop_front();
                end
                {cur_l, cur_r} = fr;
                running = 1'b1;
                c = 0;
            end else if (running) begin
                if (c == FRAME - 1) running = 1'b0;
                else c++;
            end
            if (fire) model_q.push_back(pd);
        end
        last_fire   = fire;
        last_strobe = strobe_e;

        b      = c / DIV;
        smp    = (b < SL) ? cur_l : cur_r;
        e_sclk = running && ((c % DIV) >= DIV / 2);
        e_lr   = running && (b >= SL);
        e_da   = running && slot_bit(smp, b % SL, 1);
        e_db   = running && slot_bit(smp, b % SL, 0);

        check_val("strobe_i2s", strobe_a, strobe_e);
        check_val("level_i2s", lvl_a, model_q.size());
        check_val("ready_i2s", if_a.s_ready, model_q.size() != DEPTH);
        check_val("underrun_i2s", ur_a, exp_ur);
        check_val("sclk_i2s", sclk_a, e_sclk);
        check_val("lrclk_i2s", lrclk_a, e_lr);
        check_val("dout_i2s", dout_a, e_da);
        check_val("strobe_lj", strobe_b, strobe_e);
        check_val("level_lj", lvl_b, model_q.size());
        check_val("ready_lj", if_b.s_ready, model_q.size() != DEPTH);
        check_val("underrun_lj", ur_b, exp_ur);
        check_val("sclk_lj", sclk_b, e_sclk);
        check_val("lrclk_lj", lrclk_b, e_lr);
        check_val("dout_lj", dout_b, e_db);
    endtask

    initial begin
        drive(1'b0, '0, '0);
        @(posedge MCLK);
        #1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Fixed pattern through both framings, one frame then back to idle.
        drive(1'b1, 24'hA5A5A5, 24'h5A5A5A);
        tick();
        drive(1'b0, '0, '0);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (FRAME + 16) tick();

        // Underrun from an empty FIFO, clear, then set and clear on the same edge.
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (FRAME + 16) tick();
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        underrun_clr = 1'b1;
        tick();
        enable = 1'b0;
        underrun_clr = 1'b0;
        repeat (FRAME + 16) tick();
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;

        // Backpressure: five frames offered while idle, fifth accepted after the first load.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 24'($urandom), 24'($urandom));
            tick();
        end
        enable = 1'b1;
        for (int n = 0; n < 2 * FRAME && !last_fire; n++) tick();
        check_val("bp_accept_timeout", last_fire, 1'b1);
        drive(1'b0, '0, '0);

        // Drop enable at bit 40 of a frame; the frame completes, then re-enable.
        for (int n = 0; n < 2 * FRAME && !last_strobe; n++) tick();
        check_val("strobe_wait_timeout", last_strobe, 1'b1);
        repeat (40 * DIV) tick();
        enable = 1'b0;
        repeat (FRAME + 20) tick();
        enable = 1'b1;
        repeat (3 * FRAME) tick();

        // Random traffic, enable, clears and rare resets.
        for (int i = 0; i < 6000; i++) begin
            drive($urandom_range(0, 3) == 0, 24'($urandom), 24'($urandom));
            enable       = ($urandom_range(0, 99) < 90);
            underrun_clr = ($urandom_range(0, 63) == 0);
            reset        = ($urandom_range(0, 2999) == 0);
            tick();
        end

        // Reset in the middle of a frame.
        reset = 1'b0;
        underrun_clr = 1'b0;
        drive(1'b1, 24'($urandom), 24'($urandom));
        enable = 1'b1;
        repeat (100) tick();
        drive(1'b0, '0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        enable = 1'b0;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
